traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
Two-road traffic-light controller with pedestrian walk request. It sits directly downstream of the clock divider and consumes the divider's slow square wave `s` as its time base. A rising edge of `s` is one tick. All logic runs on the fast system clock, so there is no derived-clock domain. State dwell times are counted in ticks, and the main road holds green until side demand arrives.

Parameters:
GREEN_TICKS, 8, minimum main-road green duration in ticks
YELLOW_TICKS, 2, yellow duration for either road
ALLRED_TICKS, 1, all-red clearance duration
SIDE_TICKS, 6, side-road green duration
CW, 4, width of the dwell counter; every *_TICKS value must be in the range 1 to 2^CW

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
s  input  1  divided-clock level from the clock divider, synchronous to clk
car_side  input  1  side-road vehicle sensor, level, synchronous
ped_req  input  1  pedestrian button, level or pulse, synchronous
main_light  output  3  main-road lamps {red,yellow,green}, one-hot
side_light  output  3  side-road lamps {red,yellow,green}, one-hot
walk  output  1  pedestrian walk lamp
ped_pending  output  1  a latched pedestrian request is waiting
remain  output  CW  ticks remaining in the current state (dwell counter value)

Behaviour:
- Tick detection:
  - s_d is a register of s; it resets to 0.
  - tick = s & ~s_d, a one-clk pulse per rising edge of s.
  - If s=1 at reset release, a tick occurs on the first clk edge.
  - s held at a constant level produces no further ticks.
- States:
  - MAIN_G: main=001, side=100
  - MAIN_Y: main=010, side=100
  - RED1: main=100, side=100
  - SIDE_G: main=100, side=001
  - SIDE_Y: main=100, side=010
  - RED2: main=100, side=100
- Lamp outputs are decoded directly from the state register, so they change on the same clk edge as the state.
- Dwell counter cnt (CW bits), drives remain:
  - On entry to any state, cnt is loaded with that state's *_TICKS-1.
  - On each tick with cnt>0, cnt decrements.
- Transitions (all evaluated only on a tick with cnt==0):
  - MAIN_G -> MAIN_Y when (car_side | ped_pending | ped_req). Otherwise stay in MAIN_G with cnt held at 0, so green extends indefinitely.
  - MAIN_Y -> RED1, RED1 -> SIDE_G, SIDE_G -> SIDE_Y, SIDE_Y -> RED2, RED2 -> MAIN_G. These are unconditional.
- Pedestrian logic:
  - ped_pending is set on any clk with ped_req=1 while not entering SIDE_G.
  - On the RED1->SIDE_G edge: walk is set to (ped_pending | ped_req) and ped_pending is cleared. The request is consumed.
  - walk stays constant for the whole of SIDE_G and clears on the SIDE_G->SIDE_Y edge.
  - ped_req asserted during SIDE_G after entry sets ped_pending, which is served on the next cycle. It does not extend the current walk.
- car_side is not latched; it is sampled only at the MAIN_G exit check.
- Reset (asynchronous; also applies mid-operation):
  - state=MAIN_G, cnt=GREEN_TICKS-1, s_d=0, walk=0, ped_pending=0.
  - Outputs: main=001, side=100, remain=GREEN_TICKS-1.
- Invariant: main and side are never both non-red. In every state at least one road shows 100.
- Latency: lamp change on the same clk edge as the qualifying tick; no extra pipeline stage.

Test Plan:
1. Reset: assert rst mid-run with s toggling -> immediately main=001, side=100, walk=0, ped_pending=0, remain=7; all values hold while rst=1.
2. Full cycle: defaults, s toggling every 4 clk (tick every 8 clk), car_side=1 -> MAIN_G 8 ticks, MAIN_Y 2, RED1 1, SIDE_G 6, SIDE_Y 2, RED2 1, then back to MAIN_G; remain counts 7..0 in MAIN_G.
3. No demand: car_side=0, ped_req=0, 30 ticks -> stays MAIN_G with remain=0. Then car_side=1 for one clk just before a tick -> MAIN_Y on that tick.
4. Pedestrian: 1-clk ped_req pulse in MAIN_G -> ped_pending=1 next clk; cycle runs; walk=1 throughout SIDE_G (6 ticks); ped_pending=0 from SIDE_G entry; walk=0 in SIDE_Y.
5. ped_req during SIDE_G -> ped_pending=1 and walk unchanged; the next SIDE_G has walk=1. ped_req coincident with the RED1->SIDE_G edge -> walk=1 and ped_pending=0.
6. Stuck s: s held 1 for 100 clk -> exactly one tick, cnt decrements once; s held 0 -> no state change.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light controller with latched pedestrian request.
// Dwell times are counted in rising edges of the divided clock level s, sampled on clk.
module traffic_light_ctrl #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int SIDE_TICKS   = 6,
  parameter int CW           = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s,
  input  logic          car_side,
  input  logic          ped_req,
  output logic [2:0]    main_light,
  output logic [2:0]    side_light,
  output logic          walk,
  output logic          ped_pending,
  output logic [CW-1:0] remain
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED2   = 3'd5
  } state_t;

  localparam logic [CW-1:0] L_GREEN  = CW'(GREEN_TICKS - 1);
  localparam logic [CW-1:0] L_YELLOW = CW'(YELLOW_TICKS - 1);
  localparam logic [CW-1:0] L_ALLRED = CW'(ALLRED_TICKS - 1);
  localparam logic [CW-1:0] L_SIDE   = CW'(SIDE_TICKS - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_s_d;
  logic          r_walk;
  logic          w_walk_nxt;
  logic          r_ped_pending;
  logic          w_pend_nxt;
  logic          w_tick;
  logic          w_demand;
  logic          w_enter_side;
  logic          w_leave_side;

  function automatic logic [CW-1:0] dwell_load(input state_t st);
    case (st)
      MAIN_G:  dwell_load = L_GREEN;
      MAIN_Y:  dwell_load = L_YELLOW;
      RED1:    dwell_load = L_ALLRED;
      SIDE_G:  dwell_load = L_SIDE;
      SIDE_Y:  dwell_load = L_YELLOW;
      RED2:    dwell_load = L_ALLRED;
      default: dwell_load = L_GREEN;
    endcase
  endfunction

  assign w_tick   = s & ~r_s_d;
  assign w_demand = car_side | r_ped_pending | ped_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= MAIN_G;
      r_cnt         <= L_GREEN;
      r_s_d         <= 1'b0;
      r_walk        <= 1'b0;
      r_ped_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_s_d         <= s;
      r_walk        <= w_walk_nxt;
      r_ped_pending <= w_pend_nxt;
    end
  end

  // Transitions only fire on a tick with the dwell counter exhausted; MAIN_G parks at 0 without demand.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_tick) begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end else begin
        case (r_state)
          MAIN_G:  if (w_demand) w_state_nxt = MAIN_Y;
          MAIN_Y:  w_state_nxt = RED1;
          RED1:    w_state_nxt = SIDE_G;
          SIDE_G:  w_state_nxt = SIDE_Y;
          SIDE_Y:  w_state_nxt = RED2;
          RED2:    w_state_nxt = MAIN_G;
          default: w_state_nxt = MAIN_G;
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = dwell_load(w_state_nxt);
      end
    end
  end

  // A request arriving on the SIDE_G entry edge is served immediately instead of being latched.
  always_comb begin
    w_enter_side = (r_state == RED1)   && (w_state_nxt == SIDE_G);
    w_leave_side = (r_state == SIDE_G) && (w_state_nxt == SIDE_Y);
    w_walk_nxt   = r_walk;
    w_pend_nxt   = r_ped_pending | ped_req;
    if (w_enter_side) begin
      w_walk_nxt = r_ped_pending | ped_req;
      w_pend_nxt = 1'b0;
    end else if (w_leave_side) begin
      w_walk_nxt = 1'b0;
    end
  end

  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    case (r_state)
      MAIN_G:  main_light = LAMP_GREEN;
      MAIN_Y:  main_light = LAMP_YELLOW;
      SIDE_G:  side_light = LAMP_GREEN;
      SIDE_Y:  side_light = LAMP_YELLOW;
      default: begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
      end
    endcase
  end

  assign walk        = r_walk;
  assign ped_pending = r_ped_pending;
  assign remain      = r_cnt;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and randomized bench for traffic_light_ctrl against a phase-table reference model.
module tb_traffic_light_ctrl;

  localparam int G  = 8;
  localparam int Y  = 2;
  localparam int A  = 1;
  localparam int SD = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s;
  logic          car_side;
  logic          ped_req;
  logic [2:0]    main_light;
  logic [2:0]    side_light;
  logic          walk;
  logic          ped_pending;
  logic [CW-1:0] remain;

  traffic_light_ctrl #(
    .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A), .SIDE_TICKS(SD), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .s(s), .car_side(car_side), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light), .walk(walk),
    .ped_pending(ped_pending), .remain(remain)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;

  // Reference model: phase index into a table of lamps and dwell lengths
  int         dwell [6] = '{G, Y, A, SD, Y, A};
  logic [2:0] mlamp [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] slamp [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int   m_phase;
  int   m_cnt;
  logic m_sd, m_walk, m_pend;

  int   sdiv;
  logic s_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = G - 1; m_sd = 1'b0; m_walk = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_step(input logic sv, input logic cv, input logic pv);
    logic tk;
    int   nxt;
    tk = sv & ~m_sd;
    m_sd = sv;
    nxt = m_phase;
    if (tk) begin
      if (m_cnt > 0) m_cnt--;
      else if (m_phase != 0 || cv || m_pend || pv) begin
        nxt = (m_phase + 1) % 6;
        m_cnt = dwell[nxt] - 1;
      end
    end
    if (nxt == 3 && m_phase == 2) begin
      m_walk = m_pend | pv;
      m_pend = 1'b0;
    end else begin
      if (pv) m_pend = 1'b1;
      if (nxt == 4) m_walk = 1'b0;
    end
    m_phase = nxt;
  endtask

  task automatic check_all();
    chk("main_light", main_light, mlamp[m_phase]);
    chk("side_light", side_light, slamp[m_phase]);
    chk("walk", walk, m_walk);
    chk("ped_pending", ped_pending, m_pend);
    chk("remain", remain, m_cnt);
    chk("one_road_red", (main_light == 3'b100) || (side_light == 3'b100), 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_main"}, main_light, 3'b001);
    chk({tag, "_side"}, side_light, 3'b100);
    chk({tag, "_walk"}, walk, 1'b0);
    chk({tag, "_pend"}, ped_pending, 1'b0);
    chk({tag, "_remain"}, remain, G - 1);
  endtask

  task automatic cyc(input logic sv, input logic cv, input logic pv);
    @(negedge clk);
    s = sv; car_side = cv; ped_req = pv;
    @(posedge clk);
    model_step(sv, cv, pv);
    #1 check_all();
  endtask

  // s toggles every 4 clk, giving one tick per 8 clk
  task automatic tcyc(input logic cv, input logic pv);
    sdiv++;
    if (sdiv == 4) begin
      sdiv = 0;
      s_lvl = ~s_lvl;
    end
    cyc(s_lvl, cv, pv);
  endtask

  task automatic ticks(input int n, input logic cv, input logic pv);
    repeat (n * 8) tcyc(cv, pv);
  endtask

  task automatic wait_phase(input int p, input logic cv);
    int k;
    k = 0;
    while (m_phase != p && k < 400) begin
      tcyc(cv, 1'b0);
      k++;
    end
    chk("wait_phase_in_budget", k < 400, 1'b1);
  endtask

  task automatic hold_s(input logic sv, input int n);
    repeat (n) cyc(sv, 1'b1, 1'b0);
    s_lvl = sv;
    sdiv = 0;
  endtask

  initial begin
    logic [CW-1:0] r0;
    rst = 1'b1; s = 1'b0; car_side = 1'b0; ped_req = 1'b0;
    sdiv = 0; s_lvl = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset_initial");
    @(negedge clk) rst = 1'b0;

    // Full cycle with side demand present
    ticks(24, 1'b1, 1'b0);

    // No demand: green parks at remain 0
    ticks(30, 1'b0, 1'b0);
    chk("park_main", main_light, 3'b001);
    chk("park_remain", remain, 0);
    while (!(sdiv == 3 && s_lvl == 1'b0)) tcyc(1'b0, 1'b0);
    tcyc(1'b1, 1'b0);
    chk("car_pulse_main_y", main_light, 3'b010);

    // Pedestrian pulse in MAIN_G
    wait_phase(0, 1'b0);
    ticks(9, 1'b0, 1'b0);
    tcyc(1'b0, 1'b1);
    chk("ped_latched", ped_pending, 1'b1);
    wait_phase(3, 1'b0);
    chk("walk_in_side_g", walk, 1'b1);
    chk("pend_cleared", ped_pending, 1'b0);
    wait_phase(4, 1'b0);
    chk("walk_off_side_y", walk, 1'b0);

    // Request during SIDE_G is deferred to the next SIDE_G
    wait_phase(3, 1'b1);
    tcyc(1'b1, 1'b1);
    chk("ped_in_side_g_pend", ped_pending, 1'b1);
    chk("ped_in_side_g_walk", walk, 1'b0);
    wait_phase(0, 1'b0);
    wait_phase(3, 1'b0);
    chk("deferred_walk", walk, 1'b1);

    // Request coincident with RED1 -> SIDE_G
    wait_phase(2, 1'b1);
    while (!(sdiv == 3 && s_lvl == 1'b0)) tcyc(1'b1, 1'b0);
    tcyc(1'b1, 1'b1);
    chk("coinc_side", side_light, 3'b001);
    chk("coinc_walk", walk, 1'b1);
    chk("coinc_pend", ped_pending, 1'b0);

    // Stuck s: one tick for a long high, none for a long low
    wait_phase(0, 1'b1);
    hold_s(1'b0, 4);
    r0 = remain;
    hold_s(1'b1, 100);
    chk("stuck_high_one_tick", remain, r0 - 1'b1);
    hold_s(1'b0, 100);
    chk("stuck_low_no_tick", remain, r0 - 1'b1);
    chk("stuck_low_main", main_light, 3'b001);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) s_lvl = ~s_lvl;
      cyc(s_lvl, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset mid-run with s still toggling
    wait_phase(3, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("reset_async");
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) s = ~s;
      @(posedge clk) #1 check_reset_vals("reset_hold");
    end
    @(negedge clk);
    s = 1'b1; rst = 1'b0;
    s_lvl = 1'b1; sdiv = 0;
    @(posedge clk);
    model_step(1'b1, car_side, ped_req);
    #1 check_all();
    chk("release_tick", remain, G - 2);
    ticks(20, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
